// File: rtl/mod241_chunk_accum.sv
// Streaming mod-241 accumulator for per-chunk partial residues of a 400-bit operand.
// It emits one canonical residue per frame, with the beat count and a framing-error flag.
module mod241_chunk_accum #(
  parameter int N_CHUNKS = 67
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic [6:0] out_count,
  output logic       out_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [6:0] LIMIT = 7'(N_CHUNKS);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] res_q, res_d;
  logic [6:0] count_q, count_d;
  logic       err_q, err_d;

  logic       beat;
  logic [8:0] sum;
  logic [7:0] acc_red;
  logic [6:0] cnt_inc;
  logic       at_limit;

  // Operands never exceed 240 + 255 = 495, so at most two subtractions are needed.
  function automatic logic [7:0] red241(input logic [8:0] s);
    if (s >= 9'd482)
      return 8'(s - 9'd482);
    else if (s >= 9'd241)
      return 8'(s - 9'd241);
    else
      return s[7:0];
  endfunction

  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
    beat      = in_valid && in_ready;
    sum       = {1'b0, (state_q == S_ACC) ? acc_q : 8'd0} + {1'b0, in_data};
    acc_red   = red241(sum);
    cnt_inc   = ((state_q == S_ACC) ? cnt_q : 7'd0) + 7'd1;
    at_limit  = (cnt_inc == LIMIT);

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_ACC: begin
        if (beat) begin
          acc_d   = acc_red;
          cnt_d   = cnt_inc;
          state_d = S_ACC;
          // A long frame is cut at the limit; the next beat opens a new frame.
          if (in_last || at_limit) begin
            state_d = S_DONE;
            res_d   = acc_red;
            count_d = cnt_inc;
            err_d   = (in_last != at_limit);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = 8'd0;
          cnt_d   = 7'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= 7'd0;
      res_q   <= 8'd0;
      count_q <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_res   = res_q;
  assign out_count = count_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_mod241_chunk_accum.sv
// Directed bench for mod241_chunk_accum; a reference model pushes expected frame
// results into a queue that is popped when the DUT presents a result.
module tb_mod241_chunk_accum;

  localparam int N = 67;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [6:0] out_count;
  logic       out_err;

  typedef struct packed {
    logic [7:0] res;
    logic [6:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   m_acc;
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;

  mod241_chunk_accum #(.N_CHUNKS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    m_cnt++;
    m_acc = (m_acc + int'(d)) % 241;
    if (l || m_cnt == N) begin
      sb.push_back('{res: 8'(m_acc), cnt: 7'(m_cnt), err: (l != (m_cnt == N))});
      m_acc = 0;
      m_cnt = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_last  = 1'b0;
  endtask

  // Called at the negedge right after the frame-ending beat was accepted.
  task automatic expect_result(input string tag);
    exp_t e;
    chk({tag, "_out_valid_latency"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      $display("frame %s: res=%0d count=%0d err=%0d (expected %0d/%0d/%0d)",
               tag, out_res, out_count, out_err, e.res, e.cnt, e.err);
      chk({tag, "_res"},   32'(out_res),   32'(e.res));
      chk({tag, "_count"}, 32'(out_count), 32'(e.cnt));
      chk({tag, "_err"},   32'(out_err),   32'(e.err));
    end
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] h_res;
    logic [6:0] h_cnt;
    logic       h_err;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    m_acc     = 0;
    m_cnt     = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_res",   32'(out_res),   32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);
    chk("reset_out_err",   32'(out_err),   32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);

    // 67 x 240, last on 67
    for (int i = 1; i <= N; i++) begin
      send(8'd240, i == N);
      if (i < N) chk("f240_no_early_valid", 32'(out_valid), 32'd0);
    end
    expect_result("f240");

    // 67 x 255 exercises the double subtraction
    for (int i = 1; i <= N; i++) send(8'd255, i == N);
    expect_result("f255");

    // short frame
    send(8'd100, 1'b0);
    send(8'd100, 1'b0);
    send(8'd100, 1'b1);
    expect_result("short");

    // long frame: 67 beats of 1 with no last, truncated at the limit
    for (int i = 1; i <= N; i++) send(8'd1, 1'b0);
    expect_result("long");
    // 68th beat opens a new frame, closed by one more beat
    send(8'd1, 1'b0);
    chk("long_new_frame_pending", 32'(out_valid), 32'd0);
    send(8'd1, 1'b1);
    expect_result("long_next");

    // backpressure with in_valid pending while DONE
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    h_res = out_res;
    h_cnt = out_count;
    h_err = out_err;
    chk("bp_res_value", 32'(h_res), 32'd50);
    in_valid = 1'b1;
    in_data  = 8'd7;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_res_stable",     32'(out_res),   32'(h_res));
      chk("bp_count_stable",   32'(out_count), 32'(h_cnt));
      chk("bp_err_stable",     32'(out_err),   32'(h_err));
      chk("bp_in_ready_low",   32'(in_ready),  32'd0);
    end
    expect_result("bp");
    // in_valid stayed high through the output handshake; the beat goes in now
    send(8'd7, 1'b1);
    expect_result("bp_next");

    // reset in the middle of a frame while stale outputs are nonzero
    for (int i = 1; i <= 30; i++) send(8'd5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    m_cnt = 0;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_res",   32'(out_res),   32'd0);
    chk("midreset_out_count", 32'(out_count), 32'd0);
    chk("midreset_out_err",   32'(out_err),   32'd0);
    chk("midreset_in_ready",  32'(in_ready),  32'd1);
    chk("midreset_sb_empty",  32'(sb.size()), 32'd0);

    // zeros with a single 241 beat
    for (int i = 1; i <= N; i++) send((i == 10) ? 8'd241 : 8'd0, i == N);
    expect_result("zero241");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
